// File: rtl/phy_rx_unstripe.sv
// Receive-side unstriper: each 8-bit lane is assembled into 32-bit words, which are
// merged back into one stream with even words from lane 0 and odd words from lane 1.
module phy_rx_unstripe #(
  parameter int FIFO_DEPTH  = 2,
  parameter int IDLE_RESYNC = 8
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic        valid_in_0,
  input  logic [7:0]  data_in_1,
  input  logic        valid_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        err_frame,
  output logic        err_skew
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = (IDLE_RESYNC > 0) ? $clog2(IDLE_RESYNC + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_RESYNC);

  typedef enum logic { EXPECT0 = 1'b0, EXPECT1 = 1'b1 } state_e;

  state_e        state_q;
  logic [1:0]    byte_cnt_q [2];
  logic [23:0]   shift_q    [2];
  logic [31:0]   mem_q      [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q   [2];
  logic [PW-1:0] rd_ptr_q   [2];
  logic [CW-1:0] fill_q     [2];
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   data_out_q;
  logic          valid_out_q, err_frame_q, err_skew_q;

  logic [7:0] lane_data [2];
  logic [1:0] lane_valid;
  logic [1:0] wr, pop, abort, ovf;
  logic       sel, flush, idle, resync;

  assign lane_data[0] = data_in_0;
  assign lane_data[1] = data_in_1;
  assign lane_valid   = {valid_in_1, valid_in_0};
  assign sel          = (state_q == EXPECT1);

  // NOTE: every output of this block gets a value on every path (defaults first),
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    wr    = '0;
    pop   = '0;
    abort = '0;
    ovf   = '0;
    for (int l = 0; l < 2; l++) begin
      wr[l]    = lane_valid[l] && (byte_cnt_q[l] == 2'd3);
      abort[l] = !lane_valid[l] && (byte_cnt_q[l] != 2'd0);
      pop[l]   = (fill_q[l] != '0) && (sel == 1'(l));
      // A full FIFO popped on the same edge has room for the incoming word.
      ovf[l]   = wr[l] && (fill_q[l] == FULL_CNT) && !pop[l];
    end
    flush  = |ovf;
    idle   = (lane_valid == 2'b00) && (fill_q[0] == '0) && (fill_q[1] == '0);
    idle_d = '0;
    if (idle) idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
    resync = (IDLE_RESYNC != 0) && idle && (idle_d == IDLE_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q     <= EXPECT0;
      idle_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_skew_q  <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        byte_cnt_q[l] <= '0;
        shift_q[l]    <= '0;
        wr_ptr_q[l]   <= '0;
        rd_ptr_q[l]   <= '0;
        fill_q[l]     <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (lane_valid[l]) shift_q[l] <= {shift_q[l][15:0], lane_data[l]};
        if (flush) begin
          byte_cnt_q[l] <= '0;
          wr_ptr_q[l]   <= '0;
          rd_ptr_q[l]   <= '0;
          fill_q[l]     <= '0;
        end else begin
          byte_cnt_q[l] <= lane_valid[l] ? byte_cnt_q[l] + 2'd1 : 2'd0;
          if (wr[l])  wr_ptr_q[l] <= wr_ptr_q[l] + PW'(1);
          if (pop[l]) rd_ptr_q[l] <= rd_ptr_q[l] + PW'(1);
          fill_q[l] <= fill_q[l] + CW'(wr[l]) - CW'(pop[l]);
        end
      end
      // A pop on the overflow edge still presents its word.
      valid_out_q <= |pop;
      if (|pop) data_out_q <= mem_q[sel][rd_ptr_q[sel]];
      err_frame_q <= |abort;
      err_skew_q  <= flush;
      idle_q      <= idle_d;
      if (flush || resync) state_q <= EXPECT0;
      else if (|pop)       state_q <= sel ? EXPECT0 : EXPECT1;
    end
  end

  // NOTE: word storage carries no reset; the fill counters alone say what is valid.
  always_ff @(posedge clk_4f) begin
    for (int l = 0; l < 2; l++) begin
      if (wr[l] && !flush) mem_q[l][wr_ptr_q[l]] <= {shift_q[l], lane_data[l]};
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign err_frame = err_frame_q;
  assign err_skew  = err_skew_q;

endmodule

// File: tb/tb_phy_rx_unstripe.sv
// Directed bench for phy_rx_unstripe: a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_phy_rx_unstripe;

  localparam int DEPTH = 2;
  localparam int IDLE_RESYNC = 8;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in_0, data_in_1;
  logic        valid_in_0, valid_in_1;
  logic [31:0] data_out;
  logic        valid_out, err_frame, err_skew;

  int checks = 0;
  int failures = 0;

  phy_rx_unstripe #(.FIFO_DEPTH(DEPTH), .IDLE_RESYNC(IDLE_RESYNC)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_in_0(data_in_0), .valid_in_0(valid_in_0),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1),
    .data_out(data_out), .valid_out(valid_out),
    .err_frame(err_frame), .err_skew(err_skew)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lane byte lists, word queues, owed lane, idle count.
  logic [7:0]  mb0[$], mb1[$];
  logic [31:0] mq0[$], mq1[$];
  bit          m_sel = 1'b0;
  int          m_idle = 0;
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0, m_frame = 1'b0, m_skew = 1'b0;

  initial forever begin
    logic [31:0] nw0, nw1;
    bit h0, h1, idle_now;
    @(posedge clk_4f or negedge reset);
    if (!reset) begin
      mb0.delete(); mb1.delete(); mq0.delete(); mq1.delete();
      m_sel = 1'b0; m_idle = 0; m_data = '0;
      m_valid = 1'b0; m_frame = 1'b0; m_skew = 1'b0;
    end else begin
      idle_now = !valid_in_0 && !valid_in_1 && mq0.size() == 0 && mq1.size() == 0;
      m_valid = 1'b0; m_frame = 1'b0; m_skew = 1'b0;
      h0 = 1'b0; h1 = 1'b0; nw0 = '0; nw1 = '0;
      if (!m_sel && mq0.size() > 0) begin m_data = mq0.pop_front(); m_valid = 1'b1; end
      else if (m_sel && mq1.size() > 0) begin m_data = mq1.pop_front(); m_valid = 1'b1; end
      if (valid_in_0) begin
        mb0.push_back(data_in_0);
        if (mb0.size() == 4) begin nw0 = {mb0[0], mb0[1], mb0[2], mb0[3]}; h0 = 1'b1; mb0.delete(); end
      end else if (mb0.size() != 0) begin m_frame = 1'b1; mb0.delete(); end
      if (valid_in_1) begin
        mb1.push_back(data_in_1);
        if (mb1.size() == 4) begin nw1 = {mb1[0], mb1[1], mb1[2], mb1[3]}; h1 = 1'b1; mb1.delete(); end
      end else if (mb1.size() != 0) begin m_frame = 1'b1; mb1.delete(); end
      if ((h0 && mq0.size() >= DEPTH) || (h1 && mq1.size() >= DEPTH)) begin
        mq0.delete(); mq1.delete(); mb0.delete(); mb1.delete();
        m_sel = 1'b0; m_skew = 1'b1;
      end else begin
        if (h0) mq0.push_back(nw0);
        if (h1) mq1.push_back(nw1);
        if (m_valid) m_sel = !m_sel;
      end
      if (idle_now) begin
        if (m_idle < IDLE_RESYNC) m_idle++;
        if (IDLE_RESYNC != 0 && m_idle == IDLE_RESYNC) m_sel = 1'b0;
      end else m_idle = 0;
    end
  end

  initial forever begin
    @(negedge clk_4f);
    check("cmp_valid", {31'd0, valid_out}, {31'd0, m_valid});
    check("cmp_frame", {31'd0, err_frame}, {31'd0, m_frame});
    check("cmp_skew",  {31'd0, err_skew},  {31'd0, m_skew});
    check("cmp_data",  data_out, m_data);
  end

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    valid_in_0 = v0; data_in_0 = d0; valid_in_1 = v1; data_in_1 = d1;
    @(negedge clk_4f);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic send_word(input bit lane, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      if (lane) drive(1'b0, 8'h00, 1'b1, t[31:24]);
      else      drive(1'b1, t[31:24], 1'b0, 8'h00);
      t = t << 8;
    end
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] d);
    check({name, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    check({name, "_data"}, data_out, d);
  endtask

  initial begin
    reset = 1'b1;
    valid_in_0 = 1'b0; valid_in_1 = 1'b0; data_in_0 = '0; data_in_1 = '0;
    #2 reset = 1'b0;
    @(negedge clk_4f);
    #1;

    // 1: random traffic under reset, then release.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 8'($urandom));
      expect_out("t1_rst", 1'b0, 32'h0);
      check("t1_rst_err", {30'd0, err_frame, err_skew}, 32'h0);
    end
    reset = 1'b1;
    idle(3);
    expect_out("t1_rel", 1'b0, 32'h0);

    // 2: aligned lanes.
    drive(1'b1, 8'h11, 1'b1, 8'hAA);
    drive(1'b1, 8'h22, 1'b1, 8'hBB);
    drive(1'b1, 8'h33, 1'b1, 8'hCC);
    drive(1'b1, 8'h44, 1'b1, 8'hDD);
    check("t2_latency", {31'd0, valid_out}, 32'd0);
    idle(1); expect_out("t2_w0", 1'b1, 32'h11223344);
    idle(1); expect_out("t2_w1", 1'b1, 32'hAABBCCDD);
    idle(1); expect_out("t2_hold", 1'b0, 32'hAABBCCDD);
    idle(10);

    // 3: lane 1 leads lane 0 by three cycles.
    drive(1'b0, 8'h00, 1'b1, 8'hAA);
    drive(1'b0, 8'h00, 1'b1, 8'hBB);
    drive(1'b0, 8'h00, 1'b1, 8'hCC);
    drive(1'b1, 8'h11, 1'b1, 8'hDD);
    drive(1'b1, 8'h22, 1'b0, 8'h00);
    drive(1'b1, 8'h33, 1'b0, 8'h00);
    drive(1'b1, 8'h44, 1'b0, 8'h00);
    check("t3_wait", {31'd0, valid_out}, 32'd0);
    idle(1); expect_out("t3_w0", 1'b1, 32'h11223344);
    idle(1); expect_out("t3_w1", 1'b1, 32'hAABBCCDD);
    check("t3_skew", {31'd0, err_skew}, 32'd0);
    idle(10);

    // 4: aborted partial word on lane 0.
    drive(1'b1, 8'h01, 1'b0, 8'h00);
    drive(1'b1, 8'h02, 1'b0, 8'h00);
    idle(1);
    check("t4_frame", {31'd0, err_frame}, 32'd1);
    drive(1'b1, 8'h05, 1'b0, 8'h00);
    check("t4_frame_end", {31'd0, err_frame}, 32'd0);
    drive(1'b1, 8'h06, 1'b0, 8'h00);
    drive(1'b1, 8'h07, 1'b0, 8'h00);
    drive(1'b1, 8'h08, 1'b0, 8'h00);
    idle(1); expect_out("t4_w", 1'b1, 32'h05060708);
    idle(10);

    // 5: lane 1 overflows while lane 0 is silent.
    send_word(1'b1, 32'h10203040);
    send_word(1'b1, 32'h50607080);
    check("t5_no_skew", {31'd0, err_skew}, 32'd0);
    send_word(1'b1, 32'h90A0B0C0);
    check("t5_skew", {31'd0, err_skew}, 32'd1);
    check("t5_no_valid", {31'd0, valid_out}, 32'd0);
    idle(1);
    check("t5_skew_end", {31'd0, err_skew}, 32'd0);
    send_word(1'b0, 32'hDEADBEEF);
    idle(1); expect_out("t5_w", 1'b1, 32'hDEADBEEF);
    idle(10);

    // 6: idle gap returns the owed lane to 0.
    drive(1'b1, 8'h01, 1'b1, 8'h05);
    drive(1'b1, 8'h02, 1'b1, 8'h06);
    drive(1'b1, 8'h03, 1'b1, 8'h07);
    drive(1'b1, 8'h04, 1'b1, 8'h08);
    send_word(1'b0, 32'h090A0B0C);
    idle(10);
    send_word(1'b0, 32'hCAFEF00D);
    idle(1); expect_out("t6_resync", 1'b1, 32'hCAFEF00D);
    idle(10);
    // Same three words without the gap: the lane 0 word is held.
    drive(1'b1, 8'h01, 1'b1, 8'h05);
    drive(1'b1, 8'h02, 1'b1, 8'h06);
    drive(1'b1, 8'h03, 1'b1, 8'h07);
    drive(1'b1, 8'h04, 1'b1, 8'h08);
    send_word(1'b0, 32'h090A0B0C);
    send_word(1'b0, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("t6_held", {31'd0, valid_out}, 32'd0);
    end
    send_word(1'b1, 32'h13579BDF);
    idle(1); expect_out("t6_l1", 1'b1, 32'h13579BDF);
    idle(1); expect_out("t6_l0", 1'b1, 32'hCAFEF00D);
    idle(10);

    // 7: both lanes abort together -> one pulse.
    drive(1'b1, 8'h11, 1'b1, 8'h22);
    idle(1);
    check("t7_frame", {31'd0, err_frame}, 32'd1);
    idle(1);
    check("t7_single", {31'd0, err_frame}, 32'd0);
    idle(10);

    // 8: reset with a word queued and a partial word in flight.
    send_word(1'b0, 32'h0BADF00D);
    reset = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 8'h88);
    expect_out("t8_rst", 1'b0, 32'h0);
    reset = 1'b1;
    idle(3);
    expect_out("t8_after", 1'b0, 32'h0);
    check("t8_err", {30'd0, err_frame, err_skew}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
